// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative M-extension multiply/divide sequencer.
//   Accepts one op over start_valid/start_ready, runs XLEN iterations of
//   shift-add multiply or restoring divide, then holds {result2,result}
//   until done_ready.
// Ports:
//   i_clk, i_rst_n (async active-low)
//   i_start_valid / o_start_ready, i_op (00 MULU, 01 MUL, 10 DIVU, 11 DIV),
//   i_x, i_y operands, i_flush synchronous abort,
//   o_done_valid / i_done_ready, o_result (lo / quotient),
//   o_result2 (hi / remainder), o_busy.
// Build option: MULDIV_EARLY_OUT_EN -- zero operand skips CALC, result next cycle.
//
// state  | meaning
// S_IDLE | waiting for a request
// S_CALC | one iteration per cycle, r_cnt = iteration index
// S_DONE | result presented until consumed
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start_valid,
   output logic            o_start_ready,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_x,
   input  logic [XLEN-1:0] i_y,
   input  logic            i_flush,
   output logic            o_done_valid,
   input  logic            i_done_ready,
   output logic [XLEN-1:0] o_result,
   output logic [XLEN-1:0] o_result2,
   output logic            o_busy
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_is_div, r_neg, r_sx, r_yzero;
   logic [XLEN-1:0] r_b, r_hi, r_lo;

   logic            w_accept, w_last, w_early;
   logic            w_sx, w_sy;
   logic [XLEN-1:0] w_ax, w_ay;
   logic [XLEN:0]   w_madd, w_dshift, w_ddiff;
   logic            w_dge;
   logic [XLEN-1:0] w_hi_n, w_lo_n;
   logic [2*XLEN-1:0] w_prod, w_prod_f;
   logic [XLEN-1:0] w_quo_f, w_rem_f, w_res_f, w_res2_f;
   logic            w_early_y0;

   assign w_accept = i_start_valid & o_start_ready;
   assign w_last   = (r_cnt == CW'(XLEN-1));

   // op[0] selects the signed variant for both MUL and DIV
   assign w_sx = i_op[0] & i_x[XLEN-1];
   assign w_sy = i_op[0] & i_y[XLEN-1];
   assign w_ax = w_sx ? -i_x : i_x;
   assign w_ay = w_sy ? -i_y : i_y;

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early = (i_x == '0) || (i_y == '0);
`else
   assign w_early = 1'b0;
`endif
   assign w_early_y0 = i_op[1] & (i_y == '0);

   // multiply: {r_hi,r_lo} shifts right, r_lo starts as the multiplier
   assign w_madd = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};

   // divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
   assign w_dshift = {r_hi, r_lo[XLEN-1]};
   assign w_ddiff  = w_dshift - {1'b0, r_b};
   assign w_dge    = ~w_ddiff[XLEN];

   assign w_hi_n = r_is_div ? (w_dge ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0])
                            : w_madd[XLEN:1];
   assign w_lo_n = r_is_div ? {r_lo[XLEN-2:0], w_dge}
                            : {w_madd[0], r_lo[XLEN-1:1]};

   assign w_prod   = {w_hi_n, w_lo_n};
   assign w_prod_f = r_neg ? -w_prod : w_prod;
   // divide-by-zero keeps the all-ones quotient unsigned; remainder still follows x
   assign w_quo_f  = (r_neg & ~r_yzero) ? -w_lo_n : w_lo_n;
   assign w_rem_f  = r_sx ? -w_hi_n : w_hi_n;

   assign w_res_f  = r_is_div ? w_quo_f : w_prod_f[XLEN-1:0];
   assign w_res2_f = r_is_div ? w_rem_f : w_prod_f[2*XLEN-1:XLEN];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
         S_CALC:  if (i_flush) w_state_nxt = S_IDLE;
                  else if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (i_flush || i_done_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_done_valid  = 1'b0;
      o_busy        = 1'b1;
      o_start_ready = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            o_busy        = 1'b0;
            o_start_ready = ~i_flush;
         end
         S_DONE:  o_done_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg     <= 1'b0;
         r_sx      <= 1'b0;
         r_yzero   <= 1'b0;
         r_b       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         o_result  <= '0;
         o_result2 <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_is_div <= i_op[1];
         r_neg    <= w_sx ^ w_sy;
         r_sx     <= w_sx;
         r_yzero  <= (i_y == '0);
         r_hi     <= '0;
         r_b      <= i_op[1] ? w_ay : w_ax;
         r_lo     <= i_op[1] ? w_ax : w_ay;
         if (w_early) begin
            o_result  <= w_early_y0 ? '1 : '0;
            o_result2 <= w_early_y0 ? i_x : '0;
         end
      end else if (r_state == S_CALC && !i_flush) begin
         r_cnt <= r_cnt + CW'(1);
         r_hi  <= w_hi_n;
         r_lo  <= w_lo_n;
         if (w_last) begin
            o_result  <= w_res_f;
            o_result2 <= w_res2_f;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [1:0]  op = 2'd0;
   logic [31:0] x = '0, y = '0;
   logic        flush = 1'b0;
   logic        done_valid;
   logic        done_ready = 1'b0;
   logic [31:0] result, result2;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state
   bit          m_active = 1'b0;
   int          m_done_cyc = 0;
   int          m_acc_cyc = 0;
   int          m_lat = 0;
   logic [31:0] m_res = '0, m_res2 = '0;
   logic [31:0] m_prev = '0, m_prev2 = '0;

   muldiv_seq #(.XLEN(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_start_valid(start_valid), .o_start_ready(start_ready),
      .i_op(op), .i_x(x), .i_y(y), .i_flush(flush),
      .o_done_valid(done_valid), .i_done_ready(done_ready),
      .o_result(result), .o_result2(result2), .o_busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void model(input logic [1:0] mop, input logic [31:0] a, b,
                                 output logic [31:0] r, output logic [31:0] r2);
      logic [63:0] p;
      int sa, sb;
      sa = a; sb = b;
      r = '0; r2 = '0;
      case (mop)
         2'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; r2 = p[63:32]; end
         2'd1: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0]; r2 = p[63:32];
         end
         2'd2: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; r2 = a; end
            else begin r = a / b; r2 = a % b; end
         end
         default: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; r2 = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; r2 = 0; end
            else begin r = sa / sb; r2 = sa % sb; end
         end
      endcase
   endfunction

   function automatic int latency(input logic [31:0] a, b);
`ifdef MULDIV_EARLY_OUT_EN
      if (a == 0 || b == 0) return 1;
`endif
      return 33;
   endfunction

   task automatic compare_loop();
      bit exp_dv;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_dv = m_active && (cyc >= m_done_cyc);
            check("done_valid", done_valid, exp_dv);
            check("busy", busy, m_active);
            check("start_ready", start_ready, !m_active && !flush);
            check("result", result, exp_dv ? m_res : m_prev);
            check("result2", result2, exp_dv ? m_res2 : m_prev2);
         end
      end
   endtask

   // presents a request, keeps start_valid up a few cycles while busy and
   // scrambles the operands so anything not captured on accept shows up
   task automatic issue(input logic [1:0] iop, input logic [31:0] a, b);
      @(posedge clk); #1;
      start_valid = 1'b1; op = iop; x = a; y = b;
      @(posedge clk); #1;
      model(iop, a, b, m_res, m_res2);
      m_lat      = latency(a, b);
      m_acc_cyc  = cyc;
      m_done_cyc = cyc - 1 + m_lat;
      m_active   = 1'b1;
      x = $urandom; y = $urandom; op = 2'($urandom_range(0, 3));
      repeat (3) @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   task automatic finish_op(input int hold, input bit lit, input logic [31:0] er, er2);
      int n;
      n = 0;
      @(negedge clk);
      while (done_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (done_valid !== 1'b1) begin
         check("done_timeout", done_valid, 1'b1);
      end else begin
         check("latency", cyc - (m_acc_cyc - 1), m_lat);
         if (lit) begin
            check("lit_result", result, er);
            check("lit_result2", result2, er2);
            check("model_result", m_res, er);
            check("model_result2", m_res2, er2);
         end
      end
      repeat (hold) @(negedge clk);
      @(posedge clk); #1 done_ready = 1'b1;
      @(posedge clk); #1 done_ready = 1'b0;
      m_active = 1'b0;
      m_prev = m_res; m_prev2 = m_res2;
   endtask

   task automatic run(input logic [1:0] iop, input logic [31:0] a, b,
                      input bit lit, input logic [31:0] er, er2, input int hold);
      issue(iop, a, b);
      finish_op(hold, lit, er, er2);
   endtask

   initial begin
      fork compare_loop(); join_none
      #1;
      check("rst_result", result, 32'h0);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_start_ready", start_ready, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 32'hFFFF_FFFE, 10);
      run(2'd1, 32'hFFFF_FFFD, 32'd7,         1, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
      run(2'd3, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1);
      run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h0,         0);
      run(2'd2, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 32'd5,         2);
      run(2'd2, 32'd100,       32'd7,         1, 32'd14,        32'd2,         0);
      run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1,         32'h0,         0);
      run(2'd3, 32'd7,         32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1,         0);
      run(2'd3, 32'hFFFF_FFF8, 32'd0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 0);
      run(2'd0, 32'd0,         32'd5,         1, 32'h0,         32'h0,         0);
      run(2'd3, 32'd0,         32'd3,         1, 32'h0,         32'h0,         0);
      run(2'd0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0,         32'h1,         0);
      for (int i = 0; i < 6; i++)
         run(2'($urandom_range(0, 3)), $urandom, $urandom, 0, 32'h0, 32'h0, i % 3);

      // flush around CALC iteration 10: no result, previous outputs retained
      issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (7) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      m_active = 1'b0;
      repeat (40) @(posedge clk);

      // flush wins over a simultaneous request
      #1 flush = 1'b1; start_valid = 1'b1; op = 2'd2; x = 32'd9; y = 32'd3;
      @(negedge clk);
      check("flush_start_ready", start_ready, 1'b0);
      @(posedge clk); #1 flush = 1'b0; start_valid = 1'b0;
      @(negedge clk);
      check("flush_not_accepted", busy, 1'b0);

      // async reset mid-CALC, then a clean op
      issue(2'd3, 32'hFFFF_FF00, 32'd3);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      m_active = 1'b0; m_prev = '0; m_prev2 = '0;
      #1;
      check("arst_result", result, 32'h0);
      check("arst_result2", result2, 32'h0);
      check("arst_done_valid", done_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_start_ready", start_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(2'd1, 32'd6, 32'hFFFF_FFFE, 1, 32'hFFFF_FFF4, 32'hFFFF_FFFF, 0);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
